// File: rtl/alu_muldiv_seq_pkg.sv
// Shared encodings for the MULTU/DIVU sequencer: FSM states, md_op codes and the
// ALU opsel values it borrows (these mirror the core-wide ALU ARITHM add/sub codes).
package alu_muldiv_seq_pkg;

   localparam int ALU_OPSEL_WIDTH = 6;

   localparam logic [ALU_OPSEL_WIDTH-1:0] ALU_ARITHM_ADD = 6'b100000;
   localparam logic [ALU_OPSEL_WIDTH-1:0] ALU_ARITHM_SUB = 6'b100010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } md_state_e;

   localparam logic MD_MULTU = 1'b0;
   localparam logic MD_DIVU  = 1'b1;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// EX-stage bundle around the shared ALU: pipeline operands, MULTU/DIVU request,
// ALU connection and HI/LO status. slave = sequencer, master = pipeline/ALU side.
interface alu_muldiv_seq_if #(
   parameter int WIDTH   = 32,
   parameter int OPSEL_W = 6
);
   logic [WIDTH-1:0]   ex_op_a;
   logic [WIDTH-1:0]   ex_op_b;
   logic [OPSEL_W-1:0] ex_opsel;
   logic               md_start;
   logic               md_op;
   logic [WIDTH-1:0]   md_a;
   logic [WIDTH-1:0]   md_b;
   logic [WIDTH-1:0]   alu_op_a;
   logic [WIDTH-1:0]   alu_op_b;
   logic [OPSEL_W-1:0] alu_opsel;
   logic [WIDTH-1:0]   alu_result;
   logic               alu_cf;
   logic               stall;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic               div_zero;

   modport slave (
      input  ex_op_a, ex_op_b, ex_opsel, md_start, md_op, md_a, md_b,
      input  alu_result, alu_cf,
      output alu_op_a, alu_op_b, alu_opsel,
      output stall, busy, done, hi, lo, div_zero
   );

   modport master (
      output ex_op_a, ex_op_b, ex_opsel, md_start, md_op, md_a, md_b,
      output alu_result, alu_cf,
      input  alu_op_a, alu_op_b, alu_opsel,
      input  stall, busy, done, hi, lo, div_zero
   );
endinterface

// File: rtl/alu_muldiv_step.sv
// One shift-add (MULTU) or restoring shift-subtract (DIVU) iteration; combinational.
// No flow control: the sequencer applies the result every cycle it owns the ALU.
module alu_muldiv_step
   import alu_muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             mode,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cf,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt
);

   always_comb begin
      op_a   = hi;
      hi_nxt = hi;
      lo_nxt = lo;
      if (mode == MD_DIVU) begin
         // Partial remainder is {hi,lo} << 1; a bit shifted out of hi means it already exceeds the divisor.
         op_a = {hi[WIDTH-2:0], lo[WIDTH-1]};
         if (hi[WIDTH-1] || alu_cf) begin
            hi_nxt = alu_result;
            lo_nxt = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = {hi[WIDTH-2:0], lo[WIDTH-1]};
            lo_nxt = {lo[WIDTH-2:0], 1'b0};
         end
      end else if (lo[0]) begin
         hi_nxt = {alu_cf, alu_result[WIDTH-1:1]};
         lo_nxt = {alu_result[0], lo[WIDTH-1:1]};
      end else begin
         hi_nxt = {1'b0, hi[WIDTH-1:1]};
         lo_nxt = {hi[0], lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Shares the EX ALU between the pipeline and iterative MULTU/DIVU; WIDTH+1 cycles of stall, div-by-zero finishes in 1.
// Backpressure: stall freezes IF/ID/EX from start acceptance until the DONE cycle.
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int OPSEL_W = ALU_OPSEL_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_muldiv_seq_if.slave    bus
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   md_state_e        state;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] b_reg;
   logic [CNT_W-1:0] counter;
   logic             div_zero_q;
   logic             done_q;

   logic             seq_owns;
   logic             step_mode;
   logic [WIDTH-1:0] step_op_a;
   logic [WIDTH-1:0] hi_nxt;
   logic [WIDTH-1:0] lo_nxt;

   assign seq_owns  = (state == ST_MUL) || (state == ST_DIV);
   assign step_mode = (state == ST_DIV) ? MD_DIVU : MD_MULTU;

   alu_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .mode       (step_mode),
      .hi         (hi_q),
      .lo         (lo_q),
      .alu_result (bus.alu_result),
      .alu_cf     (bus.alu_cf),
      .op_a       (step_op_a),
      .hi_nxt     (hi_nxt),
      .lo_nxt     (lo_nxt)
   );

   always_comb begin
      bus.alu_op_a  = bus.ex_op_a;
      bus.alu_op_b  = bus.ex_op_b;
      bus.alu_opsel = bus.ex_opsel;
      if (seq_owns) begin
         bus.alu_op_a  = step_op_a;
         bus.alu_op_b  = b_reg;
         bus.alu_opsel = (state == ST_DIV) ? OPSEL_W'(ALU_ARITHM_SUB) : OPSEL_W'(ALU_ARITHM_ADD);
      end
   end

   assign bus.stall    = seq_owns || ((state == ST_IDLE) && bus.md_start);
   assign bus.busy     = seq_owns;
   assign bus.done     = done_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.div_zero = div_zero_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         hi_q       <= '0;
         lo_q       <= '0;
         b_reg      <= '0;
         counter    <= '0;
         div_zero_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.md_start) begin
                  if ((bus.md_op == MD_DIVU) && (bus.md_b == '0)) begin
                     hi_q       <= bus.md_a;
                     lo_q       <= '1;
                     div_zero_q <= 1'b1;
                     done_q     <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     b_reg      <= bus.md_b;
                     counter    <= CNT_W'(WIDTH);
                     hi_q       <= '0;
                     lo_q       <= bus.md_a;
                     div_zero_q <= 1'b0;
                     state      <= (bus.md_op == MD_DIVU) ? ST_DIV : ST_MUL;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               hi_q    <= hi_nxt;
               lo_q    <= lo_nxt;
               counter <= counter - CNT_W'(1);
               if (counter == CNT_W'(1)) begin
                  done_q <= 1'b1;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural ALU and an expected-result queue.
module tb_alu_muldiv_seq;
   import alu_muldiv_seq_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_mis;
   exp_t exp_q[$];
   logic [32:0] alu_wide;

   alu_muldiv_seq_if #(.WIDTH(32), .OPSEL_W(6)) bus ();

   alu_muldiv_seq #(.WIDTH(32), .OPSEL_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: add gives carry-out, subtract gives cf=1 when there is no borrow.
   always_comb begin
      alu_wide = {1'b0, bus.alu_op_a & bus.alu_op_b};
      if (bus.alu_opsel == ALU_ARITHM_ADD)
         alu_wide = {1'b0, bus.alu_op_a} + {1'b0, bus.alu_op_b};
      else if (bus.alu_opsel == ALU_ARITHM_SUB)
         alu_wide = {1'b0, bus.alu_op_a} - {1'b0, bus.alu_op_b};
      bus.alu_result = alu_wide[31:0];
      bus.alu_cf = (bus.alu_opsel == ALU_ARITHM_SUB) ? ~alu_wide[32] : alu_wide[32];
   end

   task automatic chk1(input string tag, input logic got, input logic exp);
      n_cmp++;
      assert (got === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_md(input logic op, input logic [31:0] a, input logic [31:0] b, input int glitch);
      exp_t e;
      exp_t g;
      logic [63:0] prod;
      int k;
      logic seen;
      if (op == MD_MULTU) begin
         prod = 64'(a) * 64'(b);
         e.hi = prod[63:32]; e.lo = prod[31:0]; e.dz = 1'b0; e.lat = 33;
      end else if (b == 32'd0) begin
         e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 1;
      end else begin
         e.hi = a % b; e.lo = a / b; e.dz = 1'b0; e.lat = 33;
      end
      exp_q.push_back(e);

      @(negedge clk);
      bus.md_op = op; bus.md_a = a; bus.md_b = b; bus.md_start = 1'b1;
      #1 chk1("stall_on_start", bus.stall, 1'b1);
      @(posedge clk);
      #1;
      bus.md_start = 1'b0; bus.md_a = 32'hDEAD_BEEF; bus.md_b = 32'd0;
      if (e.lat != 1) chk1("div_zero_cleared", bus.div_zero, 1'b0);

      k = 0; seen = 1'b0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (bus.done) seen = 1'b1;
         else begin
            if (k == 5) begin
               chk1("busy_mid", bus.busy, 1'b1);
               chk1("stall_mid", bus.stall, 1'b1);
            end
            if (glitch != 0 && k == glitch) begin
               bus.md_start = 1'b1; bus.md_op = ~op; bus.md_a = 32'h1234_5678; bus.md_b = 32'd3;
            end
            if (glitch != 0 && k == glitch + 1) bus.md_start = 1'b0;
         end
      end

      g = exp_q.pop_front();
      chk1("done_seen", seen, 1'b1);
      chk32("latency", 32'(k), 32'(g.lat));
      chk1("stall_in_done", bus.stall, 1'b0);
      chk1("busy_in_done", bus.busy, 1'b0);
      chk32("hi", bus.hi, g.hi);
      chk32("lo", bus.lo, g.lo);
      chk1("div_zero", bus.div_zero, g.dz);
      @(negedge clk);
      chk1("done_one_cycle", bus.done, 1'b0);
      chk32("hi_hold", bus.hi, g.hi);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0; n_mis = 0;
      rst_n = 1'b0;
      bus.ex_op_a = '0; bus.ex_op_b = '0; bus.ex_opsel = '0;
      bus.md_start = 1'b0; bus.md_op = 1'b0; bus.md_a = '0; bus.md_b = '0;
      #2;
      chk32("rst_hi", bus.hi, 32'd0);
      chk32("rst_lo", bus.lo, 32'd0);
      chk1("rst_done", bus.done, 1'b0);
      chk1("rst_div_zero", bus.div_zero, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_stall", bus.stall, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Idle passthrough
      @(negedge clk);
      bus.ex_op_a = 32'd5; bus.ex_op_b = 32'd3; bus.ex_opsel = ALU_ARITHM_ADD;
      #1;
      chk32("pass_op_a", bus.alu_op_a, 32'd5);
      chk32("pass_op_b", bus.alu_op_b, 32'd3);
      chk32("pass_opsel", 32'(bus.alu_opsel), 32'(ALU_ARITHM_ADD));
      chk1("pass_stall", bus.stall, 1'b0);
      chk1("pass_busy", bus.busy, 1'b0);

      run_md(MD_MULTU, 32'd7, 32'd6, 0);
      run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_md(MD_DIVU, 32'd100, 32'd7, 0);
      run_md(MD_DIVU, 32'hFFFF_FFFF, 32'd1, 0);
      run_md(MD_DIVU, 32'd9, 32'd0, 0);
      run_md(MD_MULTU, 32'd3, 32'd5, 0);
      run_md(MD_MULTU, 32'h0001_2345, 32'h0000_BEEF, 10);
      run_md(MD_DIVU, 32'h8000_0001, 32'h8000_0000, 0);

      // Abort a divide with reset in its 20th iteration cycle
      @(negedge clk);
      bus.md_op = MD_DIVU; bus.md_a = 32'd1000; bus.md_b = 32'd3; bus.md_start = 1'b1;
      @(posedge clk);
      #1 bus.md_start = 1'b0;
      repeat (20) @(negedge clk);
      chk1("busy_before_abort", bus.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("abort_stall", bus.stall, 1'b0);
      chk1("abort_busy", bus.busy, 1'b0);
      chk32("abort_hi", bus.hi, 32'd0);
      chk32("abort_lo", bus.lo, 32'd0);
      chk1("abort_done", bus.done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk1("idle_after_abort_busy", bus.busy, 1'b0);
      chk1("idle_after_abort_stall", bus.stall, 1'b0);
      run_md(MD_DIVU, 32'd1000, 32'd3, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that shares the single-cycle combinational ALU between the pipeline EX stage and iterative unsigned multiply/divide (MULTU/DIVU).
- Idle: pipeline EX operands pass straight to the ALU.
- MULTU/DIVU accepted: the block stalls the pipeline, takes ownership of the ALU and runs 32 shift-add or shift-subtract iterations.
- Results are left in HI/LO for MFHI/MFLO.
- Sits in EX, between the ID/EX register and the ALU instance.

Parameters:
WIDTH, 32, operand/result width; counter sized clog2(WIDTH)+1.
OPSEL_W, 6, ALU opsel width; must equal the shared ALU_OPSEL_WIDTH define.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_op_a  in  WIDTH  pipeline ALU operand A
ex_op_b  in  WIDTH  pipeline ALU operand B
ex_opsel  in  OPSEL_W  pipeline ALU operation select
md_start  in  1  start MULTU/DIVU; sampled only in IDLE
md_op  in  1  0 = MULTU, 1 = DIVU
md_a  in  WIDTH  multiplicand / dividend
md_b  in  WIDTH  multiplier / divisor
alu_op_a  out  WIDTH  to ALU op_a
alu_op_b  out  WIDTH  to ALU op_b
alu_opsel  out  OPSEL_W  to ALU alu_opsel
alu_result  in  WIDTH  from ALU
alu_cf  in  1  from ALU carry flag
stall  out  1  freeze IF/ID/EX
busy  out  1  sequencer owns ALU
done  out  1  one-cycle completion pulse
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
div_zero  out  1  sticky until next start: last DIVU had divisor 0

Behaviour:
Reset (async, rst_n low):
- state = IDLE; hi, lo, counter, div_zero, done = 0.
- Outputs do not depend on the pre-reset state.
- Reset mid-operation aborts immediately: partial results discarded, stall drops.

ALU ownership mux:
- IDLE and DONE: alu_* = ex_*.
- MUL and DIV: alu_* driven by the sequencer.
- Opsel codes come from the shared defines: ARITHM add for MUL, ARITHM subtract for DIV.

ALU carry convention: on add, alu_cf = carry-out; on subtract, alu_cf = 1 means no borrow (a >= b).

States:
- IDLE:
  - md_start=1, md_b != 0 or md_op=0: latch b_reg = md_b and counter = WIDTH.
    - MULTU: hi = 0, lo = md_a; go to MUL.
    - DIVU: hi = 0, lo = md_a; go to DIV.
    - Clear div_zero.
  - DIVU with md_b == 0: hi = md_a, lo = all ones, div_zero = 1; go to DONE.
- MUL, one iteration per cycle:
  - ALU computes hi + b_reg.
  - If lo[0]=1: {hi, lo} <= {alu_cf, alu_result, lo[WIDTH-1:1]}.
  - Else: {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]}.
  - counter decrements; after the iteration where counter = 1, go to DONE.
- DIV, restoring, one iteration per cycle:
  - {msb, hs, ls} = {hi, lo} << 1.
  - ALU computes hs - b_reg.
  - If msb=1 or alu_cf=1: hi <= alu_result, lo <= {ls[WIDTH-1:1], 1}.
  - Else: hi <= hs, lo <= {ls[WIDTH-1:1], 0}.
  - Result: lo = quotient, hi = remainder.
  - Counter handling as in MUL.
- DONE: done = 1 for exactly this cycle; go to IDLE.

stall:
- Combinational: (IDLE and md_start) or MUL or DIV.
- Low in DONE, so the stalled instruction advances in the DONE cycle.

busy = MUL or DIV.

Latency: start accepted at edge 0; done high in the cycle after edge WIDTH (33 cycles of stall for WIDTH=32). Divide-by-zero: done in the cycle after edge 0.

Boundary rules:
- md_start outside IDLE is ignored.
- md_start held high in DONE is not re-accepted until IDLE.
- hi/lo hold their values in IDLE/DONE.
- No write to hi/lo from any other source (MTHI/MTLO out of scope).

Decomposition:
- Shared defines file additions: state encoding (IDLE, MUL, DIV, DONE as 2-bit constants), MD_MULTU/MD_DIVU, and references to the existing ARITHM add/sub opsel constants. No new literal opsel values in this block.
- One natural sub-module: alu_muldiv_step. Combinational next-{hi, lo} logic for one MUL/DIV iteration from hi, lo, alu_result, alu_cf, mode.
- The FSM, counter and ALU mux stay in alu_muldiv_seq.

Test Plan:
- Idle passthrough: ex_op_a=5, ex_op_b=3, ex_opsel=ADD, md_start=0 -> alu_op_a=5, alu_op_b=3, alu_opsel=ADD; stall=0, busy=0.
- MULTU 7×6 -> stall high from the start cycle; done pulses exactly 33 cycles later; hi=0, lo=42.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (exercises alu_cf into hi).
- DIVU 100/7 -> lo=14, hi=2.
- DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
- DIVU 9/0 -> done on the next cycle; hi=9, lo=0xFFFFFFFF, div_zero=1; a following MULTU start clears div_zero.
- Robustness:
  - Pulse md_start again in the 10th MUL cycle -> ignored; result unchanged.
  - Assert rst_n=0 in the 20th DIV cycle -> stall, busy, hi, lo = 0 immediately; state IDLE after release.
